cpu_clock_phase_gen: RTL and testbench
======================================

Name: cpu_clock_phase_gen

Overview:
- Upstream clock-enable generator for the console core.
- Derives the MARIA pixel enables (mclk0, mclk1) and the CPU phase enables (pclk1 = phi1, pclk0 = phi2) from clk_sys as single-cycle strobes.
- Stretches a CPU bus cycle from 4 to 6 mclk periods when the current access targets TIA or RIOT, which gives the 1.79/1.19 MHz behaviour.
- Its outputs feed MARIA, the CPU wrapper, TIA, RIOT, cart and RAM write enables.

Parameters:
- MCLK_DIV, 4: clk_sys cycles per mclk period. Must be even and >= 4.
- FAST_LEN, 4: mclk periods per normal CPU cycle. Must be >= 3.
- SLOW_LEN, 6: mclk periods per TIA/RIOT CPU cycle. Must be > FAST_LEN.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- slow_access  in  1  high when the decoded chip select of the current CPU cycle is TIA or RIOT.
- freeze  in  1  high stalls CPU phase generation; mclk continues.
- mclk0  out  1  one-clk_sys strobe at mclk period start.
- mclk1  out  1  one-clk_sys strobe at mclk period midpoint.
- pclk1  out  1  one-clk_sys strobe marking the start of a CPU cycle (phi1).
- pclk0  out  1  one-clk_sys strobe marking the phi2 data point of a CPU cycle.
- slow_cycle  out  1  level: the current CPU cycle is stretched.
- cyc_pos  out  3  mclk index within the current CPU cycle.

Behaviour:
- All outputs are registered. Reset values: every strobe = 0, slow_cycle = 0, cyc_pos = 0.
- Internal div counter runs 0..MCLK_DIV-1 and wraps. Reset sets div = 0.
- mclk0 = 1 exactly in the clk_sys cycle where div == 0.
- mclk1 = 1 exactly in the clk_sys cycle where div == MCLK_DIV/2.
- Free-running pattern: mclk0 and mclk1 are never high together; each fires once per MCLK_DIV clocks.
- Length select: len = slow_cycle ? SLOW_LEN : FAST_LEN.
- cyc_pos update: on each mclk1 strobe, when freeze = 0, cyc_pos advances to cyc_pos+1, wrapping to 0 after len-1.
- pclk1 = 1 coincident with the mclk1 strobe at which cyc_pos == 0.
- slow_access sampling:
  - Sampled only on the mclk1 strobe where cyc_pos == 1, i.e. the first mclk after pclk1, once the address has settled.
  - slow_cycle <= slow_access at that point.
  - slow_cycle holds until the next sample.
  - A change of slow_access at any other time has no effect.
- pclk0 = 1 coincident with the mclk1 strobe at which cyc_pos == len-1.
- Strobe ordering:
  - pclk0 and pclk1 strictly alternate, exactly one of each per CPU cycle.
  - Neither fires on a clk_sys cycle without mclk1.
- Cycle periods:
  - Fast cycle: pclk1 to pclk0 is (FAST_LEN-1)*MCLK_DIV clocks (12 at defaults); pclk1 to pclk1 is FAST_LEN*MCLK_DIV (16).
  - Slow cycle: pclk1 to pclk0 is (SLOW_LEN-1)*MCLK_DIV (20); pclk1 to pclk1 is 24.
- freeze:
  - While freeze = 1: cyc_pos holds, pclk0/pclk1 are forced 0, mclk0/mclk1 continue.
  - freeze rising on the same clk_sys as a would-be pclk strobe suppresses that strobe. The strobe is then emitted on the first mclk1 after freeze falls (cyc_pos unchanged).
- Reset mid-cycle:
  - Next clk_sys: all strobes 0, div = 0, cyc_pos = 0, slow_cycle = 0.
  - First pclk1 after rst falls occurs on the first mclk1 (MCLK_DIV/2 clocks after release).
  - No partial pclk0 is ever emitted after reset.
- Widths: cyc_pos is 3 bits, supporting SLOW_LEN <= 8. Parameter violations are flagged by a simulation-only assertion.

Test Plan:
- Reset release with slow_access = 0, freeze = 0:
  - First pclk1 at clk 2 after release.
  - Thereafter pclk1 every 16 clocks and pclk0 12 clocks after each pclk1.
  - mclk1 every 4 clocks; mclk0 every 4 clocks offset by 2.
- slow_access = 1 held only during the sample mclk1 (cyc_pos == 1): that cycle's pclk0 comes 20 clocks after pclk1 and the next pclk1 24 clocks after. slow_cycle = 1 for that cycle, then 0 on the following cycle.
- slow_access toggled everywhere except the sample point → all cycles stay fast (16-clock period).
- freeze asserted for 40 clocks mid-cycle at cyc_pos == 2:
  - mclk strobes continue; zero pclk strobes during freeze.
  - After release, pclk0 follows at cyc_pos 3 within 8 clocks (two mclk1), then normal cadence resumes.
- rst pulsed for one clock between a pclk1 and its pclk0 → that pclk0 never appears, and a new pclk1 occurs 2 clocks after release.
- Long random run (10k clocks, random slow_access/freeze) → pclk0/pclk1 strictly alternate, no two strobes of the same kind within MCLK_DIV clocks, and each pclk coincides with mclk1.

Source files
------------

// File: rtl/cpu_clock_phase_gen.sv
// Clock-enable generator: mclk pixel strobes and phi1/phi2 CPU strobes derived from clk_sys,
// with CPU cycles stretched from FAST_LEN to SLOW_LEN mclk periods for TIA/RIOT accesses.

module cpu_clock_phase_gen_param_chk #(
  parameter int MCLK_DIV = 4,
  parameter int FAST_LEN = 4,
  parameter int SLOW_LEN = 6
) (
  input logic clk_sys
);

  // Flag illegal parameter sets while simulating
  always @(posedge clk_sys) begin
    assert ((MCLK_DIV >= 4) && ((MCLK_DIV % 2) == 0) && (FAST_LEN >= 3) &&
            (SLOW_LEN > FAST_LEN) && (SLOW_LEN <= 8))
      else $error("cpu_clock_phase_gen: illegal parameter set");
  end

endmodule

module cpu_clock_phase_gen #(
  parameter int MCLK_DIV = 4,
  parameter int FAST_LEN = 4,
  parameter int SLOW_LEN = 6
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       slow_access,
  input  logic       freeze,
  output logic       mclk0,
  output logic       mclk1,
  output logic       pclk1,
  output logic       pclk0,
  output logic       slow_cycle,
  output logic [2:0] cyc_pos
);

  localparam int DW = $clog2(MCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(MCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_MID   = DW'(MCLK_DIV / 2);
  localparam logic [DW-1:0] DIV_ZERO  = DW'(0);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [2:0]    FAST_LAST = 3'(FAST_LEN - 1);
  localparam logic [2:0]    SLOW_LAST = 3'(SLOW_LEN - 1);

  logic [DW-1:0] div_r;
  logic [DW-1:0] div_nxt_s;
  logic [2:0]    pos_r;
  logic [2:0]    pos_nxt_s;
  logic [2:0]    pos_last_s;
  logic          slow_r;
  logic          mid_s;
  logic          start_s;
  logic          adv_s;
  logic          mclk0_r;
  logic          mclk1_r;
  logic          pclk1_r;
  logic          pclk0_r;
  logic [2:0]    cyc_pos_r;

  cpu_clock_phase_gen_param_chk #(
    .MCLK_DIV (MCLK_DIV),
    .FAST_LEN (FAST_LEN),
    .SLOW_LEN (SLOW_LEN)
  ) u_param_chk (
    .clk_sys (clk_sys)
  );

  // Divider successor, strobe decode and CPU position successor
  always_comb begin
    div_nxt_s  = DIV_ZERO;
    pos_nxt_s  = pos_r;
    pos_last_s = FAST_LAST;
    if (div_r == DIV_LAST) begin
      div_nxt_s = DIV_ZERO;
    end else begin
      div_nxt_s = div_r + DIV_ONE;
    end
    start_s = (div_nxt_s == DIV_ZERO);
    mid_s   = (div_nxt_s == DIV_MID);
    adv_s   = mid_s && !freeze;
    if (slow_r) begin
      pos_last_s = SLOW_LAST;
    end else begin
      pos_last_s = FAST_LAST;
    end
    // A frozen strobe leaves the position untouched so the missed pclk replays later
    if (adv_s) begin
      if (pos_r == pos_last_s) begin
        pos_nxt_s = 3'd0;
      end else begin
        pos_nxt_s = pos_r + 3'd1;
      end
    end else begin
      pos_nxt_s = pos_r;
    end
  end

  // Divider, CPU position, slow sample and registered strobes
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      div_r     <= DIV_ZERO;
      pos_r     <= 3'd0;
      slow_r    <= 1'b0;
      mclk0_r   <= 1'b0;
      mclk1_r   <= 1'b0;
      pclk1_r   <= 1'b0;
      pclk0_r   <= 1'b0;
      cyc_pos_r <= 3'd0;
    end else begin
      div_r     <= div_nxt_s;
      pos_r     <= pos_nxt_s;
      mclk0_r   <= start_s;
      mclk1_r   <= mid_s;
      pclk1_r   <= adv_s && (pos_r == 3'd0);
      pclk0_r   <= adv_s && (pos_r == pos_last_s);
      cyc_pos_r <= pos_r;
      // Address is settled one mclk after phi1, so chip-select is sampled only then
      if (adv_s && (pos_r == 3'd1)) begin
        slow_r <= slow_access;
      end else begin
        slow_r <= slow_r;
      end
    end
  end

  assign mclk0      = mclk0_r;
  assign mclk1      = mclk1_r;
  assign pclk1      = pclk1_r;
  assign pclk0      = pclk0_r;
  assign slow_cycle = slow_r;
  assign cyc_pos    = cyc_pos_r;

endmodule

// File: tb/tb_cpu_clock_phase_gen.sv
// Directed and random bench for cpu_clock_phase_gen: arithmetic reference model compared
// every cycle, strobe ordering monitor, and literal timing expectations.

module tb_cpu_clock_phase_gen;

  localparam int MCLK_DIV = 4;
  localparam int FAST_LEN = 4;
  localparam int SLOW_LEN = 6;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       slow_access;
  logic       freeze;
  logic       mclk0, mclk1, pclk1, pclk0, slow_cycle;
  logic [2:0] cyc_pos;

  int checks = 0;
  int failures = 0;

  // model state
  bit m_valid = 1'b0;
  bit alt_reset = 1'b0;
  int m_k, m_step, m_len;
  bit m_slow;
  bit e_mclk0, e_mclk1, e_pclk0, e_pclk1, e_slow;
  int e_cyc;

  cpu_clock_phase_gen #(
    .MCLK_DIV (MCLK_DIV),
    .FAST_LEN (FAST_LEN),
    .SLOW_LEN (SLOW_LEN)
  ) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .slow_access (slow_access),
    .freeze      (freeze),
    .mclk0       (mclk0),
    .mclk1       (mclk1),
    .pclk1       (pclk1),
    .pclk0       (pclk0),
    .slow_cycle  (slow_cycle),
    .cyc_pos     (cyc_pos)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: clocks since release give mclk; each unfrozen mclk1 steps the CPU cycle
  initial forever begin
    @(posedge clk_sys);
    if (rst) begin
      m_valid = 1'b1; alt_reset = 1'b1;
      m_k = 0; m_step = 0; m_slow = 1'b0;
      e_mclk0 = 1'b0; e_mclk1 = 1'b0; e_pclk0 = 1'b0; e_pclk1 = 1'b0;
      e_slow = 1'b0; e_cyc = 0;
    end else if (m_valid) begin
      m_k++;
      e_mclk0 = ((m_k % MCLK_DIV) == 0);
      e_mclk1 = ((m_k % MCLK_DIV) == MCLK_DIV / 2);
      e_cyc = m_step;
      e_pclk0 = 1'b0;
      e_pclk1 = 1'b0;
      if (e_mclk1 && !freeze) begin
        m_len = m_slow ? SLOW_LEN : FAST_LEN;
        e_pclk1 = (m_step == 0);
        e_pclk0 = (m_step == m_len - 1);
        if (m_step == 1) m_slow = slow_access;
        m_step = (m_step + 1) % m_len;
      end
      e_slow = m_slow;
    end
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk_sys);
    if (m_valid) begin
      chk("mclk0", mclk0, e_mclk0);
      chk("mclk1", mclk1, e_mclk1);
      chk("pclk1", pclk1, e_pclk1);
      chk("pclk0", pclk0, e_pclk0);
      chk("slow_cycle", slow_cycle, e_slow);
      chk("cyc_pos", cyc_pos, e_cyc);
    end
  end

  // Strobe ordering monitor independent of the model
  initial begin
    int last_kind = 0;
    int cyc = 0;
    int last_p1 = -100;
    int last_p0 = -100;
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (alt_reset) begin
        last_kind = 0;
        alt_reset = 1'b0;
      end
      if (m_valid && pclk1) begin
        chk("pclk1_on_mclk1", mclk1, 1);
        chk("alt_pclk1", last_kind, 0);
        chk("pclk1_gap", int'((cyc - last_p1) >= MCLK_DIV), 1);
        last_kind = 1;
        last_p1 = cyc;
      end
      if (m_valid && pclk0) begin
        chk("pclk0_on_mclk1", mclk1, 1);
        chk("alt_pclk0", last_kind, 1);
        chk("pclk0_gap", int'((cyc - last_p0) >= MCLK_DIV), 1);
        last_kind = 0;
        last_p0 = cyc;
      end
    end
  end

  // sel: 0 pclk1, 1 pclk0; n = negedges until seen
  task automatic wait_sig(input int sel, input int maxc, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < maxc) begin
      @(negedge clk_sys);
      n++;
      hit = (sel == 0) ? pclk1 : pclk0;
    end
    chk("wait_timeout", hit, 1);
  endtask

  initial begin
    int n, np, nm, p0_at;
    rst = 1'b1; slow_access = 1'b0; freeze = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_mclk0", mclk0, 0);
    chk("rst_mclk1", mclk1, 0);
    chk("rst_pclk1", pclk1, 0);
    chk("rst_cyc_pos", cyc_pos, 0);
    rst = 1'b0;

    // fast cadence after release
    wait_sig(0, 40, n);
    chk("first_pclk1", n, 2);
    for (int c = 0; c < 2; c++) begin
      wait_sig(1, 40, n); chk("fast_p1_to_p0", n, 12);
      wait_sig(0, 40, n); chk("fast_p0_to_p1", n, 4);
    end

    // slow_access high only across the sample mclk1
    repeat (3) @(negedge clk_sys);
    slow_access = 1'b1;
    @(negedge clk_sys);
    slow_access = 1'b0;
    wait_sig(1, 40, n); chk("slow_p1_to_p0", n + 4, 20);
    chk("slow_cycle_hi", slow_cycle, 1);
    wait_sig(0, 40, n); chk("slow_p0_to_p1", n, 4);
    wait_sig(1, 40, n); chk("next_fast_p1_to_p0", n, 12);
    chk("slow_cycle_lo", slow_cycle, 0);
    wait_sig(0, 40, n);

    // toggling everywhere but the sample point keeps cycles fast
    for (int c = 0; c < 3; c++) begin
      p0_at = -1;
      for (int i = 0; i < 16; i++) begin
        slow_access = (i == 3) ? 1'b0 : ~slow_access;
        @(negedge clk_sys);
        if (pclk0) p0_at = i;
      end
      chk("toggle_p0_pos", p0_at, 11);
      chk("toggle_period", pclk1, 1);
    end
    slow_access = 1'b0;

    // freeze across the cyc_pos 2 strobe
    repeat (6) @(negedge clk_sys);
    freeze = 1'b1;
    np = 0; nm = 0;
    repeat (40) begin
      @(negedge clk_sys);
      if (pclk0 || pclk1) np++;
      if (mclk1) nm++;
    end
    chk("freeze_no_pclk", np, 0);
    chk("freeze_mclk1_count", nm, 10);
    chk("freeze_cyc_pos", cyc_pos, 2);
    freeze = 1'b0;
    wait_sig(1, 20, n); chk("unfreeze_p0", n, 6);
    chk("unfreeze_p0_pos", cyc_pos, 3);
    wait_sig(0, 20, n); chk("unfreeze_p1", n, 4);

    // one-clock reset between pclk1 and pclk0
    repeat (5) @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    chk("midrst_cyc_pos", cyc_pos, 0);
    chk("midrst_pclk0", pclk0, 0);
    rst = 1'b0;
    wait_sig(0, 20, n); chk("midrst_first_pclk1", n, 2);
    wait_sig(1, 40, n); chk("midrst_p1_to_p0", n, 12);

    // long random run
    repeat (10000) begin
      slow_access = 1'($urandom_range(0, 1));
      freeze = ($urandom_range(0, 9) == 0);
      @(negedge clk_sys);
    end
    freeze = 1'b0;
    repeat (8) @(negedge clk_sys);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
